fetch_sequencer: RTL
====================

Name: fetch_sequencer

Overview:
- Program-counter controller that sequences the combinational instruction ROM.
- Drives the ROM address, presents each fetched instruction to the datapath with a valid/stall handshake, applies branch redirects and detects the halt opcode.
- Sits between the instruction ROM and the datapath/decoder.
- Keeps cycle and retired-instruction counters for lab performance reporting.

Parameters:
- PC_W, 4, width of the program counter and ROM address.
- INSTR_W, 9, instruction width. Opcode is instr[INSTR_W-1 -: 4].
- HALT_OPCODE, 4'b1110, opcode that terminates execution.
- CNT_W, 16, width of the cycle and retired counters.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  single-cycle pulse that begins execution from address 0.
- stall  in  1  datapath cannot accept an instruction this cycle.
- branch_taken  in  1  datapath redirects the PC. Qualified by instr_valid && !stall.
- branch_target  in  PC_W  absolute target address for a taken branch.
- inst_in  in  INSTR_W  ROM data. Combinational from inst_address, same cycle.
- inst_address  out  PC_W  ROM address; equals the PC register.
- instr  out  INSTR_W  instruction to the datapath; pass-through of inst_in.
- instr_valid  out  1  instr is a real, non-halt instruction.
- done  out  1  halt reached; held until the next start or reset.
- cycle_count  out  CNT_W  cycles spent in RUN.
- retired_count  out  CNT_W  instructions accepted by the datapath.

Behaviour:
- Reset is synchronous and active-high; single clock clk.
- Reset values: state=IDLE, pc=0, done=0, cycle_count=0, retired_count=0, instr_valid=0.
- Reset mid-RUN: at the next edge the block is in IDLE with all registers as above. No partial advance.
- States: IDLE, RUN, HALTED.
- IDLE: pc held at 0, instr_valid=0. start -> RUN; counters cleared on the same edge.
- RUN, instr_valid: combinational; 1 iff state==RUN and opcode(inst_in)!=HALT_OPCODE.
- RUN, advance: occurs when instr_valid && !stall.
  - retired_count increments.
  - If branch_taken: pc <= branch_target.
  - Otherwise: pc <= pc+1, modulo 2^PC_W (15 -> 0 wraps silently).
- RUN, stall=1: pc and retired_count hold. instr_valid stays 1 with the same instr. branch_taken is ignored.
- RUN, halt opcode at pc: at the next edge state=HALTED and done=1. pc holds at the halt address. The halt is not retired. stall and branch_taken are don't-care.
- cycle_count increments on every RUN cycle, including the halt-detect cycle and stalled cycles.
- Both counters saturate at all-ones and do not wrap.
- HALTED: done=1, instr_valid=0, counters frozen and readable. start -> RUN with pc=0, done=0, counters cleared.
- start while in RUN is ignored.
- Latency: start edge -> first instr_valid in the following cycle. One instruction per cycle maximum.

Decomposition:
- Shared package fetch_pkg holds:
  - fetch_state_t enum {IDLE, RUN, HALTED}
  - HALT_OPCODE
  - OPCODE_W=4
  - opcode field position constants, shared with the decoder
- One sub-module: sat_counter (parameter W; inputs clk, reset, clr, inc; output count; saturating). Instantiated twice, for cycle_count and retired_count.

Test Plan:
- ROM with 4 non-halt instructions then halt at address 4; start pulse, stall=0 -> inst_address steps 0,1,2,3,4; instr_valid=1 for 4 cycles; done=1 from the next edge; retired_count=4, cycle_count=5.
- stall held high for 3 cycles at pc=2 -> inst_address stays 2, instr unchanged, retired_count unchanged; on release pc becomes 3.
- branch_taken=1, branch_target=1 while pc=3 and not stalled -> next inst_address=1. Same stimulus with stall=1 -> pc stays 3.
- ROM with no halt, PC_W=4 -> pc wraps 15 -> 0; cycle_count saturates at 16'hFFFF after 65535 cycles.
- Assert reset at pc=3 in RUN -> next cycle state=IDLE, pc=0, counters 0, done=0, instr_valid=0.
- In HALTED, pulse start -> done drops, pc=0, counters cleared, execution repeats. start pulsed during RUN has no effect.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared fetch-stage definitions: sequencer states, halt opcode and opcode field layout.
package fetch_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    HALTED = 2'd2
  } fetch_state_t;

  localparam int OPCODE_W = 4;
  localparam logic [OPCODE_W-1:0] HALT_OPCODE = 4'b1110;

  // Opcode occupies the top OPCODE_W bits of the instruction word.
  localparam int DEFAULT_INSTR_W = 9;
  localparam int OPCODE_MSB = DEFAULT_INSTR_W - 1;
  localparam int OPCODE_LSB = DEFAULT_INSTR_W - OPCODE_W;

endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones; clr takes priority over inc.
module sat_counter
  import fetch_pkg::*;
#(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] count
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (inc && (count_q != {W{1'b1}})) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/fetch_sequencer.sv
// Program-counter sequencer for the instruction ROM with stall/branch handshake,
// halt detection and cycle/retired performance counters.
//
//   state  | meaning
//   IDLE   | waiting for start, pc held at 0
//   RUN    | fetching; one instruction per cycle when not stalled
//   HALTED | halt opcode seen, done held, counters frozen
module fetch_sequencer
  import fetch_pkg::*;
#(
  parameter int PC_W    = 4,
  parameter int INSTR_W = 9,
  parameter logic [OPCODE_W-1:0] HALT_OPCODE = fetch_pkg::HALT_OPCODE,
  parameter int CNT_W   = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               stall,
  input  logic               branch_taken,
  input  logic [PC_W-1:0]    branch_target,
  input  logic [INSTR_W-1:0] inst_in,
  output logic [PC_W-1:0]    inst_address,
  output logic [INSTR_W-1:0] instr,
  output logic               instr_valid,
  output logic               done,
  output logic [CNT_W-1:0]   cycle_count,
  output logic [CNT_W-1:0]   retired_count
);

  fetch_state_t    state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic            done_q, done_d;
  logic            cnt_clr;
  logic            is_halt;
  logic            advance;
  logic            in_run;

  assign is_halt     = (inst_in[INSTR_W-1 -: OPCODE_W] == HALT_OPCODE);
  assign in_run      = (state_q == RUN);
  assign instr_valid = in_run && !is_halt;
  assign advance     = instr_valid && !stall;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    done_d  = done_q;
    cnt_clr = 1'b0;
    case (state_q)
      IDLE: begin
        pc_d = '0;
        if (start) begin
          state_d = RUN;
          done_d  = 1'b0;
          cnt_clr = 1'b1;
        end
      end
      RUN: begin
        // Halt wins over stall/branch; the halt address stays on the bus.
        if (is_halt) begin
          state_d = HALTED;
          done_d  = 1'b1;
        end else if (advance) begin
          pc_d = branch_taken ? branch_target : pc_q + 1'b1;
        end
      end
      HALTED: begin
        if (start) begin
          state_d = RUN;
          pc_d    = '0;
          done_d  = 1'b0;
          cnt_clr = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        pc_d    = '0;
        done_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      pc_q    <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      done_q  <= done_d;
    end
  end

  sat_counter #(.W(CNT_W)) u_cycle_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (cnt_clr),
    .inc   (in_run),
    .count (cycle_count)
  );

  sat_counter #(.W(CNT_W)) u_retired_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (cnt_clr),
    .inc   (advance),
    .count (retired_count)
  );

  assign inst_address = pc_q;
  assign instr        = inst_in;
  assign done         = done_q;

endmodule
